// File: rtl/mc_ctrl_if.sv
// Control-side bundle between the multicycle MIPS controller and its datapath:
// instruction fields and the ALU flag come in, the ALU code, mux selects and write strobes go out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcen;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
               irwrite, memwrite, regwrite, pcen, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
               irwrite, memwrite, regwrite, pcen, illegal, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that steps each instruction through
// fetch/decode/execute/memory/writeback and drives the ALU and datapath muxes.
module mc_ctrl (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } aluop_t;

    typedef struct packed {
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
        aluop_t     aluop;
    } ctl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     st;
    state_t     nxt;
    ctl_t       ctl;
    logic       opknown;
    logic [2:0] functop;

    function automatic ctl_t ctl_for(state_t s);
        ctl_t c;
        c       = '0;
        c.aluop = ALU_ADD;
        case (s)
            FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALU_FUNCT; end
            RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BEQEX:   begin
                c.alusrca = 1'b1;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
                c.aluop   = ALU_SUB;
            end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  c.regwrite = 1'b1;
            JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state selection; op only matters in DECODE and MEMADR, unreachable codes fall back to FETCH
    always_comb begin
        opknown = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_RTYPE) ||
                  (bus.op == OP_BEQ) || (bus.op == OP_ADDI) || (bus.op == OP_J);
        nxt = FETCH;
        case (st)
            FETCH:   nxt = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JEX;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW)
                    nxt = MEMRD;
                else if (bus.op == OP_SW)
                    nxt = MEMWR;
                else
                    nxt = FETCH;
            end
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // Control word is registered together with the state it belongs to
    always_ff @(posedge clk) begin
        if (!reset) begin
            st  <= FETCH;
            ctl <= ctl_for(FETCH);
        end else begin
            st  <= nxt;
            ctl <= ctl_for(nxt);
        end
    end

    // Unknown funct codes quietly default to add
    always_comb begin
        functop = 3'b010;
        case (bus.funct)
            6'b100000: functop = 3'b010;
            6'b100010: functop = 3'b110;
            6'b100100: functop = 3'b000;
            6'b100101: functop = 3'b001;
            6'b101010: functop = 3'b111;
            default:   functop = 3'b010;
        endcase
    end

    // While reset is low the selects read as FETCH and every strobe is held off immediately
    always_comb begin
        bus.alucontrol = 3'b010;
        if (reset) begin
            case (ctl.aluop)
                ALU_SUB:   bus.alucontrol = 3'b110;
                ALU_FUNCT: bus.alucontrol = functop;
                default:   bus.alucontrol = 3'b010;
            endcase
        end
    end

    assign bus.alusrca  = reset & ctl.alusrca;
    assign bus.alusrcb  = reset ? ctl.alusrcb : 2'b01;
    assign bus.pcsrc    = reset ? ctl.pcsrc : 2'b00;
    assign bus.iord     = reset & ctl.iord;
    assign bus.memtoreg = reset & ctl.memtoreg;
    assign bus.regdst   = reset & ctl.regdst;
    assign bus.irwrite  = reset & ctl.irwrite;
    assign bus.memwrite = reset & ctl.memwrite;
    assign bus.regwrite = reset & ctl.regwrite;
    assign bus.pcen     = reset & (ctl.pcwrite | (ctl.branch & bus.zero));
    assign bus.illegal  = reset & (st == DECODE) & ~opknown;
    assign bus.state    = st;
endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised self-checking bench for mc_ctrl: each instruction is expanded into its
// expected state walk and per-state control outputs, then compared cycle by cycle.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   path[$];

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire logic [15:0] obs = {bus.alucontrol, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.iord,
                             bus.memtoreg, bus.regdst, bus.irwrite, bus.memwrite,
                             bus.regwrite, bus.pcen, bus.illegal};

    function automatic logic [2:0] alu_for_funct(logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic is_legal(logic [5:0] op);
        return op == OP_LW || op == OP_SW || op == OP_RTYPE ||
               op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

    // Expected outputs from the per-state table; fields not mentioned stay at their defaults
    function automatic logic [15:0] model_outs(int s, logic [5:0] op, logic [5:0] funct,
                                               logic z, logic rstn);
        logic [2:0] alu;
        logic       a, io, m2r, rd, ir, mw, rw, pe, il;
        logic [1:0] b, pc;
        alu = 3'b010; a = 0; b = 2'b00; pc = 2'b00;
        io = 0; m2r = 0; rd = 0; ir = 0; mw = 0; rw = 0; pe = 0; il = 0;
        if (!rstn) begin
            b = 2'b01;
        end else begin
            case (s)
                0:  begin b = 2'b01; ir = 1; pe = 1; end
                1:  begin b = 2'b11; il = !is_legal(op); end
                2:  begin a = 1; b = 2'b10; end
                3:  io = 1;
                4:  begin m2r = 1; rw = 1; end
                5:  begin io = 1; mw = 1; end
                6:  begin a = 1; alu = alu_for_funct(funct); end
                7:  begin rd = 1; rw = 1; end
                8:  begin a = 1; alu = 3'b110; pc = 2'b01; pe = z; end
                9:  begin a = 1; b = 2'b10; end
                10: rw = 1;
                11: begin pc = 2'b10; pe = 1; end
                default: ;
            endcase
        end
        return {alu, a, b, pc, io, m2r, rd, ir, mw, rw, pe, il};
    endfunction

    task automatic plan(input logic [5:0] op);
        path = {0, 1};
        case (op)
            OP_LW:    path = {0, 1, 2, 3, 4};
            OP_SW:    path = {0, 1, 2, 5};
            OP_RTYPE: path = {0, 1, 6, 7};
            OP_BEQ:   path = {0, 1, 8};
            OP_ADDI:  path = {0, 1, 9, 10};
            OP_J:     path = {0, 1, 11};
            default:  path = {0, 1};
        endcase
    endtask

    // Walks one instruction from FETCH back to FETCH; op/funct/zero are scrambled where they must not matter
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic z,
                             input string tag);
        int   s;
        logic zi;
        plan(op);
        foreach (path[i]) begin
            s  = path[i];
            zi = (s == 8) ? z : 1'($urandom);
            bus.op    = (s == 1 || s == 2) ? op : 6'($urandom);
            bus.funct = (s == 6) ? funct : 6'($urandom);
            bus.zero  = zi;
            #1;
            checks++;
            if (bus.state !== 4'(s)) begin
                errors++;
                $display("[TB] FAIL %s state step %0d: got %0d want %0d", tag, i, bus.state, s);
            end
            checks++;
            if (obs !== model_outs(s, op, funct, zi, 1'b1)) begin
                errors++;
                $display("[TB] FAIL %s outputs in state %0d: got %h want %h", tag, s, obs,
                         model_outs(s, op, funct, zi, 1'b1));
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL %s return to fetch: got %0d want 0", tag, bus.state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.op = OP_RTYPE; bus.funct = 6'b100000; bus.zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd0 || obs !== model_outs(0, 0, 0, 0, 1'b0)) begin
            errors++;
            $display("[TB] FAIL reset hold: got state %0d out %h want 0 %h", bus.state, obs,
                     model_outs(0, 0, 0, 0, 1'b0));
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== model_outs(0, 0, 0, 0, 1'b1)) begin
            errors++;
            $display("[TB] FAIL reset release: got %h want %h", obs, model_outs(0, 0, 0, 0, 1'b1));
        end
        // Abandon an R-type in its writeback step
        bus.op = OP_RTYPE; bus.funct = 6'b100010;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd7 || bus.regwrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reach rtypewb: got state %0d regwrite %b want 7 1", bus.state, bus.regwrite);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== model_outs(7, 0, 0, 0, 1'b0)) begin
            errors++;
            $display("[TB] FAIL reset in rtypewb: got %h want %h", obs, model_outs(7, 0, 0, 0, 1'b0));
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.state !== 4'd0 || bus.regwrite !== 1'b0 || bus.pcen !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got state %0d regwrite %b pcen %b want 0 0 0",
                         c, bus.state, bus.regwrite, bus.pcen);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.irwrite !== 1'b1 || bus.pcen !== 1'b1 || bus.alusrcb !== 2'b01 ||
            bus.alucontrol !== 3'b010) begin
            errors++;
            $display("[TB] FAIL first fetch: got irwrite %b pcen %b alusrcb %b alu %b want 1 1 01 010",
                     bus.irwrite, bus.pcen, bus.alusrcb, bus.alucontrol);
        end
    endtask

    task automatic test_lw_sw();
        run_instr(OP_LW, 6'($urandom), 1'b0, "lw");
        run_instr(OP_SW, 6'($urandom), 1'b1, "sw");
    endtask

    task automatic test_rtype();
        logic [5:0] functs[6];
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};
        foreach (functs[k]) run_instr(OP_RTYPE, functs[k], 1'($urandom), "rtype");
    endtask

    task automatic test_beq();
        run_instr(OP_BEQ, 6'($urandom), 1'b1, "beq taken");
        run_instr(OP_BEQ, 6'($urandom), 1'b0, "beq not taken");
    endtask

    task automatic test_j_addi();
        run_instr(OP_J, 6'($urandom), 1'b0, "j");
        run_instr(OP_ADDI, 6'($urandom), 1'b1, "addi");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'($urandom), 1'b0, "illegal");
        run_instr(6'b010101, 6'($urandom), 1'b1, "illegal2");
    endtask

    task automatic test_reset_memwr();
        bus.op = OP_SW;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd5 || bus.memwrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reach memwr: got state %0d memwrite %b want 5 1", bus.state, bus.memwrite);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.memwrite !== 1'b0 || bus.iord !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset in memwr: got memwrite %b iord %b want 0 0", bus.memwrite, bus.iord);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL memwr reset state: got %0d want 0", bus.state);
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[7];
        logic [5:0] fs[5];
        logic [5:0] op;
        logic [5:0] f;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, 6'b000000};
        fs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            f = fs[$urandom_range(0, 4)];
            if ($urandom_range(0, 4) == 0) f = 6'($urandom);
            run_instr(op, f, 1'($urandom), "random");
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
        @(negedge clk);
        test_reset();
        test_lw_sw();
        test_rtype();
        test_beq();
        test_j_addi();
        test_illegal();
        test_reset_memwr();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
